// File: rtl/apb_pkg.sv
// Shared types and defaults for the multi-slave APB master.
// Holds the FSM state type, default parameter values and the select-width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_e;

    localparam int unsigned DefAddrW     = 8;
    localparam int unsigned DefDataW     = 8;
    localparam int unsigned DefNumSlaves = 4;
    localparam int unsigned DefTimeout   = 16;

    // A single slave still needs one select bit to slice the address.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: the top address bits select one slave.
// An index beyond the slave count gives no select and valid low.
module apb_addr_decode import apb_pkg::*; #(
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned NUM_SLAVES = DefNumSlaves
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  valid
);

    localparam int unsigned SelW = sel_width(NUM_SLAVES);

    logic [SelW-1:0] idx;

    assign idx = addr[ADDR_W-1 -: SelW];

    always_comb begin
        valid = (32'(idx) < NUM_SLAVES);
        sel   = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            sel[i] = valid && (32'(idx) == i);
        end
    end

endmodule

// File: rtl/apb_master_mslave.sv
// APB master for NUM_SLAVES slaves with wait states, slave error, decode error,
// access timeout and back-to-back transfers.
module apb_master_mslave import apb_pkg::*; #(
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned NUM_SLAVES = DefNumSlaves,
    parameter int unsigned TIMEOUT    = DefTimeout
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic                         transfer,
    input  logic                         mpwrite,
    input  logic [ADDR_W-1:0]            apb_write_paddr,
    input  logic [DATA_W-1:0]            apb_write_data,
    input  logic [ADDR_W-1:0]            apb_read_paddr,
    output logic [DATA_W-1:0]            apb_read_data_out,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [ADDR_W-1:0]            paddr,
    output logic                         pwrite,
    output logic [DATA_W-1:0]            pwdata,
    output logic [NUM_SLAVES-1:0]        psel,
    output logic                         penable,
    input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]        pready,
    input  logic [NUM_SLAVES-1:0]        pslverr
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);

    apb_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic [ADDR_W-1:0]     cmd_addr;
    logic [NUM_SLAVES-1:0] cmd_sel;
    logic                  cmd_valid;
    logic                  pready_sel;
    logic                  pslverr_sel;
    logic [DATA_W-1:0]     prdata_sel;
    logic                  accept;
    logic                  complete;

    assign cmd_addr = mpwrite ? apb_write_paddr : apb_read_paddr;

    apb_addr_decode #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES)
    ) u_decode (
        .addr  (cmd_addr),
        .sel   (cmd_sel),
        .valid (cmd_valid)
    );

    assign pready_sel  = |(pready & sel_q);
    assign pslverr_sel = |(pslverr & sel_q);

    always_comb begin
        prdata_sel = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                prdata_sel = prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        accept   = 1'b0;
        complete = 1'b0;

        unique case (state_q)
            APB_IDLE: begin
                if (transfer) begin
                    if (cmd_valid) begin
                        accept = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end
                end
            end
            APB_SETUP: begin
                state_d = APB_ACCESS;
                cnt_d   = '0;
            end
            APB_ACCESS: begin
                if (pready_sel) begin
                    complete = 1'b1;
                    done_d   = 1'b1;
                    error_d  = pslverr_sel;
                    if (!write_q) begin
                        rdata_d = prdata_sel;
                    end
                end else if (cnt_q >= CntLast) begin
                    complete = 1'b1;
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // An undecodable follow-on command is left for IDLE so its error
                // done does not collide with this completion's done.
                if (complete) begin
                    if (transfer && cmd_valid) begin
                        accept = 1'b1;
                    end else begin
                        state_d = APB_IDLE;
                    end
                end
            end
            default: state_d = APB_IDLE;
        endcase

        if (accept) begin
            state_d = APB_SETUP;
            write_d = mpwrite;
            addr_d  = cmd_addr;
            wdata_d = apb_write_data;
            sel_d   = cmd_sel;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= APB_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign paddr             = addr_q;
    assign pwrite            = write_q;
    assign pwdata            = wdata_q;
    assign psel              = (state_q == APB_IDLE) ? '0 : sel_q;
    assign penable           = (state_q == APB_ACCESS);
    assign busy              = (state_q != APB_IDLE);
    assign done              = done_q;
    assign error             = error_q;
    assign apb_read_data_out = rdata_q;

endmodule
